// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the register file read path.
//   WIDTH      : data width of an architectural register
//   NREGS      : number of architectural registers
//   reg_addr_t : 5-bit register index
//   XZR        : index of the hardwired zero register
package cpu_pkg;

  localparam int WIDTH = 64;
  localparam int NREGS = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t XZR = 5'd31;

  // True when the index names a backed register (only meaningful when NREGS < 32).
  function automatic logic addr_in_range(input reg_addr_t addr, input int nregs);
    return ({1'b0, addr} < 6'(nregs));
  endfunction

endpackage : cpu_pkg

// File: rtl/regfile_read_mux.sv
// Combinational read port of the register file.
// Selects one entry, forces the zero register and out-of-range indices to 0, and
// forwards a same-cycle write so the reader sees the value being written.
//   mem      : current register contents
//   rd_addr  : register being read
//   wr_en    : write strobe from WB
//   wr_addr  : register being written this cycle
//   wr_data  : value being written this cycle
//   rd_value : resulting read value
module regfile_read_mux
  import cpu_pkg::*;
#(
  parameter int        WIDTH    = cpu_pkg::WIDTH,
  parameter int        NREGS    = cpu_pkg::NREGS,
  parameter reg_addr_t ZERO_REG = cpu_pkg::XZR
) (
  input  logic [WIDTH-1:0] mem [NREGS],
  input  reg_addr_t        rd_addr,
  input  logic             wr_en,
  input  reg_addr_t        wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_value
);

  // Zero register and unbacked indices read as 0; bypass beats storage.
  always_comb begin
    rd_value = '0;
    if (rd_addr == ZERO_REG) begin
      rd_value = '0;
    end else if (!addr_in_range(rd_addr, NREGS)) begin
      rd_value = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_value = wr_data;
    end else begin
      rd_value = mem[rd_addr];
    end
  end

endmodule : regfile_read_mux

// File: rtl/regfile_reader.sv
// 32 x 64-bit register file with two registered read ports at the ID/EX boundary.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data: write port driven by WB (never blocked by stall/flush)
//   rd_req               : decode presents a valid instruction
//   rd_addr_a/rd_addr_b  : source register indices
//   stall                : hold read outputs and valid
//   flush                : turn the next outputs into a bubble
//   rd_data_a/rd_data_b  : registered read values (one cycle latency)
//   rd_valid             : outputs belong to a live instruction
module regfile_reader
  import cpu_pkg::*;
#(
  parameter int        WIDTH    = cpu_pkg::WIDTH,
  parameter int        NREGS    = cpu_pkg::NREGS,
  parameter reg_addr_t ZERO_REG = cpu_pkg::XZR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  reg_addr_t        wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  reg_addr_t        rd_addr_a,
  input  reg_addr_t        rd_addr_b,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid
);

  logic [WIDTH-1:0] r_mem [NREGS];
  logic [WIDTH-1:0] w_rd_value_a;
  logic [WIDTH-1:0] w_rd_value_b;
  logic [WIDTH-1:0] r_rd_data_a;
  logic [WIDTH-1:0] r_rd_data_b;
  logic             r_rd_valid;

  // Storage: one enable-register per entry. Reset is folded into the enable and
  // data path so every entry clears synchronously; the zero register never loads.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
    logic             w_en;
    logic [WIDTH-1:0] w_d;

    // Per-entry enable and next value.
    always_comb begin
      w_en = 1'b0;
      w_d  = '0;
      if (reset) begin
        w_en = 1'b1;
        w_d  = '0;
      end else if (wr_en && (wr_addr == reg_addr_t'(gi)) && (wr_addr != ZERO_REG)) begin
        w_en = 1'b1;
        w_d  = wr_data;
      end else begin
        w_en = 1'b0;
        w_d  = '0;
      end
    end

    // Enable-register cell.
    always_ff @(posedge clk) begin
      if (w_en) begin
        r_mem[gi] <= w_d;
      end else begin
        r_mem[gi] <= r_mem[gi];
      end
    end
  end

  regfile_read_mux #(
    .WIDTH   (WIDTH),
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG)
  ) u_read_mux_a (
    .mem     (r_mem),
    .rd_addr (rd_addr_a),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_value(w_rd_value_a)
  );

  regfile_read_mux #(
    .WIDTH   (WIDTH),
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG)
  ) u_read_mux_b (
    .mem     (r_mem),
    .rd_addr (rd_addr_b),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_value(w_rd_value_b)
  );

  // Output stage: reset > flush > stall > normal. Data is captured even when
  // rd_req is low; only valid tracks the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_rd_valid  <= 1'b0;
    end else if (flush) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_rd_valid  <= 1'b0;
    end else if (stall) begin
      r_rd_data_a <= r_rd_data_a;
      r_rd_data_b <= r_rd_data_b;
      r_rd_valid  <= r_rd_valid;
    end else begin
      r_rd_data_a <= w_rd_value_a;
      r_rd_data_b <= w_rd_value_b;
      r_rd_valid  <= rd_req;
    end
  end

  assign rd_data_a = r_rd_data_a;
  assign rd_data_b = r_rd_data_b;
  assign rd_valid  = r_rd_valid;

endmodule : regfile_reader
